// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter onto one single-outstanding memory port with response timeout
// Ports: clk; rst (async, active-low); if_* fetch requester; d_* load/store requester; mem_* memory.
// Build option MEM_ARBITER_ROUND_ROBIN_EN alternates simultaneous grants; otherwise data always wins.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_ready_out,
  output logic        if_rvalid_out,
  output logic [31:0] if_rdata_out,
  output logic        if_err_out,
  input  logic        d_read_en_in,
  input  logic        d_write_en_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  input  logic [3:0]  d_byte_en_in,
  output logic        d_ready_out,
  output logic        d_rvalid_out,
  output logic [31:0] d_rdata_out,
  output logic        d_err_out,
  output logic        mem_valid_out,
  input  logic        mem_ready_in,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [3:0]  mem_byte_en_out,
  output logic        mem_ren_out,
  output logic        mem_wen_out,
  input  logic        mem_rvalid_in,
  input  logic [31:0] mem_rdata_in
);
  typedef enum logic [1:0] {IDLE, REQUEST, RESPONSE, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q, wdata_q, if_rdata_q, d_rdata_q;
  logic [3:0] be_q;
  logic gnt_d, wr_q, err_q, d_req, pick_d, grant, tmo, fin;
  assign d_req = d_read_en_in | d_write_en_in;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_d;
  assign pick_d = d_req & ~(if_req_in & last_d);
`else
  assign pick_d = d_req;
`endif
  // ready is combinational so the grant is visible in the request cycle; masked while in reset
  assign grant = rst & (state == IDLE) & (if_req_in | d_req);
  assign tmo = ~mem_rvalid_in & (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign fin = (state == RESPONSE) & (mem_rvalid_in | tmo);
  always_comb begin
    state_nx = (state == IDLE && (if_req_in || d_req)) ? REQUEST :
               (state == REQUEST && mem_ready_in) ? RESPONSE :
               fin ? DONE :
               (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      gnt_d <= 1'b0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_d <= 1'b1;
`endif
    end else begin
      cnt <= (state == RESPONSE) ? cnt + CW'(1) : '0;
      if (grant) begin
        gnt_d <= pick_d;
        wr_q <= pick_d & d_write_en_in;
        addr_q <= pick_d ? d_addr_in : if_addr_in;
        wdata_q <= pick_d ? d_wdata_in : '0;
        be_q <= pick_d ? d_byte_en_in : 4'hf;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        last_d <= pick_d;
`endif
      end
      if (fin) begin
        err_q <= tmo;
        if (gnt_d) d_rdata_q <= (mem_rvalid_in & ~wr_q) ? mem_rdata_in : '0;
        else if_rdata_q <= (mem_rvalid_in & ~wr_q) ? mem_rdata_in : '0;
      end
    end
  end
  assign if_ready_out = grant & ~pick_d;
  assign d_ready_out = grant & pick_d;
  assign mem_valid_out = (state == REQUEST);
  assign mem_ren_out = mem_valid_out & ~wr_q;
  assign mem_wen_out = mem_valid_out & wr_q;
  assign mem_addr_out = addr_q;
  assign mem_wdata_out = wdata_q;
  assign mem_byte_en_out = be_q;
  assign if_rvalid_out = (state == DONE) & ~gnt_d;
  assign d_rvalid_out = (state == DONE) & gnt_d;
  assign if_err_out = if_rvalid_out & err_q;
  assign d_err_out = d_rvalid_out & err_q;
  assign if_rdata_out = if_rdata_q;
  assign d_rdata_out = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-timeline model of the arbiter checked against the DUT every cycle
module tb_mem_arbiter;
  localparam int T = 16;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 0, rst = 0;
  logic if_req_in, if_ready_out, if_rvalid_out, if_err_out;
  logic [31:0] if_addr_in, if_rdata_out;
  logic d_read_en_in, d_write_en_in, d_ready_out, d_rvalid_out, d_err_out;
  logic [31:0] d_addr_in, d_wdata_in, d_rdata_out;
  logic [3:0] d_byte_en_in, mem_byte_en_out;
  logic mem_valid_out, mem_ready_in, mem_ren_out, mem_wen_out, mem_rvalid_in;
  logic [31:0] mem_addr_out, mem_wdata_out, mem_rdata_in;
  mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_ready_out(if_ready_out),
    .if_rvalid_out(if_rvalid_out), .if_rdata_out(if_rdata_out), .if_err_out(if_err_out),
    .d_read_en_in(d_read_en_in), .d_write_en_in(d_write_en_in), .d_addr_in(d_addr_in),
    .d_wdata_in(d_wdata_in), .d_byte_en_in(d_byte_en_in), .d_ready_out(d_ready_out),
    .d_rvalid_out(d_rvalid_out), .d_rdata_out(d_rdata_out), .d_err_out(d_err_out),
    .mem_valid_out(mem_valid_out), .mem_ready_in(mem_ready_in), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_byte_en_out(mem_byte_en_out), .mem_ren_out(mem_ren_out),
    .mem_wen_out(mem_wen_out), .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic [3:0] be;
    bit rd, wr;
    int rdly, rsp;
  } txn_t;
  txn_t iq[$], dq[$];
  int total = 0, bad = 0, cyc = 0, t0;
  int free_at = 0, v0 = -1, v1 = -1, r0 = -1, rv_at = -1, done_at = -1;
  bit cur_d, cur_wr, cur_err, last_d = 1, spur = 0, glitch = 0, chk_en = 0;
  logic [31:0] cur_addr, cur_wdata, cur_res, cur_mdata;
  logic [3:0] cur_be;
  logic [31:0] e_if_rdata = 0, e_d_rdata = 0;
  bit e_if_rdy = 0, e_d_rdy = 0, e_valid = 0, e_if_rv = 0, e_d_rv = 0;
  string order;
  int if_rv_seen, d_rv_seen, if_err_seen, d_err_seen, valid_cnt, wen_cnt, ren_cnt;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
    end
  endtask
  task automatic chk_s(input string n, input string a, input string e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%s exp=%s", n, a, e);
    end
  endtask
  task automatic check_zero(input string n);
    chk({n, "_ctl"}, {if_ready_out, if_rvalid_out, if_err_out, d_ready_out, d_rvalid_out, d_err_out,
                      mem_valid_out, mem_ren_out, mem_wen_out, mem_byte_en_out}, 64'd0);
    chk({n, "_rdata"}, {if_rdata_out, d_rdata_out}, 64'd0);
    chk({n, "_mem"}, {mem_addr_out, mem_wdata_out}, 64'd0);
  endtask
  task automatic zero_inputs();
    {if_req_in, d_read_en_in, d_write_en_in, mem_ready_in, mem_rvalid_in} = '0;
    {if_addr_in, d_addr_in, d_wdata_in, mem_rdata_in} = '0;
    d_byte_en_in = '0;
  endtask
  task automatic clr_obs();
    order = "";
    {if_rv_seen, d_rv_seen, if_err_seen, d_err_seen} = {-1, -1, -1, -1};
    {valid_cnt, wen_cnt, ren_cnt} = {0, 0, 0};
  endtask
  task automatic push(input bit d, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int rdly, input int rsp, input logic [31:0] rdat);
    txn_t t;
    t.addr = a; t.wdata = wd; t.be = be; t.rd = rd; t.wr = wr; t.rdly = rdly; t.rsp = rsp; t.rdata = rdat;
    if (d) dq.push_back(t);
    else iq.push_back(t);
  endtask
  // One cycle: outputs implied by the current transaction's timeline, memory/requester drive, then grant.
  task automatic step();
    txn_t t;
    bit pd;
    @(posedge clk); #1;
    cyc++;
    e_valid = (cyc >= v0 && cyc <= v1);
    e_if_rv = (cyc == done_at) && !cur_d;
    e_d_rv = (cyc == done_at) && cur_d;
    if (e_if_rv) e_if_rdata = cur_res;
    if (e_d_rv) e_d_rdata = cur_res;
    mem_ready_in = (cyc == v1) || (spur && !(cyc >= v0 && cyc <= v1));
    mem_rvalid_in = (cyc == rv_at) || (spur && !(cyc >= r0 && cyc < done_at));
    mem_rdata_in = (cyc == rv_at) ? cur_mdata : $urandom;
    if_req_in = iq.size() > 0;
    if_addr_in = iq.size() > 0 ? iq[0].addr : 32'd0;
    d_read_en_in = (dq.size() > 0 && dq[0].rd) || glitch;
    d_write_en_in = dq.size() > 0 && dq[0].wr;
    d_addr_in = dq.size() > 0 ? dq[0].addr : 32'd0;
    d_wdata_in = dq.size() > 0 ? dq[0].wdata : 32'd0;
    d_byte_en_in = dq.size() > 0 ? dq[0].be : 4'd0;
    e_if_rdy = 0;
    e_d_rdy = 0;
    if (cyc >= free_at && (iq.size() > 0 || dq.size() > 0)) begin
      pd = dq.size() > 0 && (iq.size() == 0 || !RR || !last_d);
      last_d = pd;
      t = pd ? dq.pop_front() : iq.pop_front();
      cur_d = pd;
      cur_wr = pd && t.wr;
      cur_addr = t.addr;
      cur_wdata = pd ? t.wdata : 32'd0;
      cur_be = pd ? t.be : 4'hf;
      cur_mdata = t.rdata;
      v0 = cyc + 1;
      v1 = cyc + 1 + t.rdly;
      r0 = v1 + 1;
      cur_err = t.rsp >= T;
      rv_at = cur_err ? -1 : r0 + t.rsp;
      done_at = cur_err ? r0 + T : rv_at + 1;
      cur_res = (cur_err || cur_wr) ? 32'd0 : t.rdata;
      free_at = done_at + 1;
      e_if_rdy = !pd;
      e_d_rdy = pd;
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((iq.size() > 0 || dq.size() > 0 || cyc < free_at) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL drain cycle budget expired at cyc=%0d", cyc);
    end
    step();
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("if_ready", if_ready_out, e_if_rdy);
    chk("d_ready", d_ready_out, e_d_rdy);
    chk("mem_valid", mem_valid_out, e_valid);
    chk("mem_ren", mem_ren_out, e_valid & ~cur_wr);
    chk("mem_wen", mem_wen_out, e_valid & cur_wr);
    if (e_valid) begin
      chk("mem_addr", mem_addr_out, cur_addr);
      chk("mem_wdata", mem_wdata_out, cur_wdata);
      chk("mem_be", mem_byte_en_out, cur_be);
    end
    chk("if_rvalid", if_rvalid_out, e_if_rv);
    chk("if_err", if_err_out, e_if_rv & cur_err);
    chk("if_rdata", if_rdata_out, e_if_rdata);
    chk("d_rvalid", d_rvalid_out, e_d_rv);
    chk("d_err", d_err_out, e_d_rv & cur_err);
    chk("d_rdata", d_rdata_out, e_d_rdata);
    if (if_ready_out) order = {order, "I"};
    if (d_ready_out) order = {order, "D"};
    if (if_rvalid_out) if_rv_seen = cyc;
    if (d_rvalid_out) d_rv_seen = cyc;
    if (if_err_out) if_err_seen = cyc;
    if (d_err_out) d_err_seen = cyc;
    if (mem_valid_out) valid_cnt++;
    if (mem_wen_out) wen_cnt++;
    if (mem_ren_out) ren_cnt++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end
  initial begin
    zero_inputs();
    clr_obs();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1;
    chk_en = 1;
    clr_obs(); t0 = cyc + 1;
    push(0, 1, 0, 32'h100, 0, 4'h0, 0, 0, 32'hDEADBEEF);
    drain();
    chk("lit_if_latency", if_rv_seen, t0 + 3);
    chk("lit_if_rdata", if_rdata_out, 32'hDEADBEEF);
    chk_s("lit_grant_fetch", order, "I");
    clr_obs(); t0 = cyc + 1; spur = 1;
    push(1, 0, 1, 32'h2000, 32'h12345678, 4'b0011, 3, 2, 32'hAAAA5555);
    drain();
    spur = 0;
    chk("lit_wr_valid_cycles", valid_cnt, 4);
    chk("lit_wr_wen_cycles", wen_cnt, 4);
    chk("lit_wr_done", d_rv_seen, t0 + 8);
    chk("lit_wr_rdata", d_rdata_out, 0);
    clr_obs();
    push(1, 1, 1, 32'h3000, 32'hCAFEF00D, 4'hf, 0, 0, 32'h77777777);
    drain();
    chk("lit_rw_wen", wen_cnt, 1);
    chk("lit_rw_ren", ren_cnt, 0);
    chk("lit_rw_rdata", d_rdata_out, 0);
    clr_obs();
    for (int i = 0; i < 4; i++) begin
      push(0, 1, 0, 32'h400 + 32'(i * 4), 0, 4'h0, i % 2, i % 2, 32'h11110000 + 32'(i));
      push(1, 1, 0, 32'h800 + 32'(i * 4), 0, 4'hf, (i + 1) % 2, 0, 32'h22220000 + 32'(i));
    end
    drain();
    chk_s("lit_arb_order", order, RR ? "IDIDIDID" : "DDDDIIII");
    chk("lit_arb_if_rdata", if_rdata_out, 32'h11110003);
    chk("lit_arb_d_rdata", d_rdata_out, 32'h22220003);
    clr_obs(); t0 = cyc + 1;
    push(1, 1, 0, 32'h4000, 0, 4'hf, 0, T, 32'h99999999);
    repeat (3) step();
    glitch = 1;
    repeat (3) step();
    glitch = 0;
    drain();
    chk("lit_tmo_done", d_rv_seen, t0 + 18);
    chk("lit_tmo_err", d_err_seen, t0 + 18);
    chk("lit_tmo_rdata", d_rdata_out, 0);
    chk_s("lit_withdrawn_dropped", order, "D");
    clr_obs(); t0 = cyc + 1;
    push(0, 1, 0, 32'h4400, 0, 4'h0, 0, T - 1, 32'h55AA55AA);
    drain();
    chk("lit_late_done", if_rv_seen, t0 + 18);
    chk("lit_late_no_err", if_err_seen, -1);
    chk("lit_late_rdata", if_rdata_out, 32'h55AA55AA);
    clr_obs(); t0 = cyc + 1;
    push(1, 1, 0, 32'h6000, 0, 4'hf, 0, T, 32'h1);
    repeat (5) step();
    #2;
    rst = 0;
    chk_en = 0;
    #1;
    check_zero("async_rst");
    iq.delete(); dq.delete();
    {free_at, v0, v1, r0, rv_at, done_at} = {0, -1, -1, -1, -1, -1};
    {e_if_rdy, e_d_rdy, e_valid, e_if_rv, e_d_rv} = '0;
    e_if_rdata = 0; e_d_rdata = 0; last_d = 1;
    zero_inputs();
    @(posedge clk); #1;
    cyc++;
    check_zero("held_rst");
    rst = 1;
    chk_en = 1;
    repeat (20) step();
    chk("lit_rst_no_rvalid", d_rv_seen, -1);
    clr_obs(); t0 = cyc + 1;
    push(0, 1, 0, 32'h500, 0, 4'h0, 1, 1, 32'h0BADF00D);
    drain();
    chk("lit_post_rst_done", if_rv_seen, t0 + 5);
    chk("lit_post_rst_rdata", if_rdata_out, 32'h0BADF00D);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
